// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control sequencer.
// A Moore FSM steps the shared datapath through fetch, decode, execute, memory and writeback.
// Outputs decode from the current state and the opcode latched in DECODE. The only exception is
// FETCH, where ir_write and pc_write follow mem_ready.
// Memory states (FETCH, MEM_RD, MEM_WR) count consecutive not-ready cycles. The FSM traps once
// MEM_WAIT_LIMIT of them have passed.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_eq,
  output logic       pc_write_ne,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [5:0] alu_op,
  output logic       trap,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StExecI   = 4'd3,
    StAluWb   = 4'd4,
    StMemAddr = 4'd5,
    StMemRd   = 4'd6,
    StMemWb   = 4'd7,
    StMemWr   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StTrap    = 4'd15
  } state_e;

  // Last wait count that may still be followed by another not-ready cycle.
  localparam logic [7:0] WaitLast = 8'(MEM_WAIT_LIMIT - 1);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic       in_mem_state;

  // The zero flag qualifies pc_write_eq/pc_write_ne in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  // State, opcode latch and wait counter; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StFetch;
      op_q    <= 6'h00;
      wait_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic, memory wait timeout and Moore output decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_d      = 8'h00;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_src      = 2'b00;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 6'h00;
    trap        = 1'b0;
    in_mem_state = 1'b0;

    unique case (state_q)
      StFetch: begin
        in_mem_state = 1'b1;
        mem_read     = 1'b1;
        alu_src_b    = 2'b01;
        ir_write     = mem_ready;
        pc_write     = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        op_d      = op;
        case (op)
          6'h00:               state_d = StExecR;
          6'h08, 6'h0d, 6'h0f: state_d = StExecI;
          6'h23, 6'h2b:        state_d = StMemAddr;
          6'h04, 6'h05:        state_d = StBranch;
          6'h02:               state_d = StJump;
          default:             state_d = StTrap;
        endcase
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_op    = op_q;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = op_q;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == 6'h00);
        state_d   = StFetch;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == 6'h2b) ? StMemWr : StMemRd;
      end
      StMemRd: begin
        in_mem_state = 1'b1;
        iord         = 1'b1;
        mem_read     = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        in_mem_state = 1'b1;
        iord         = 1'b1;
        mem_write    = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StBranch: begin
        alu_src_a   = 1'b1;
        alu_op      = 6'h04;
        pc_src      = 2'b01;
        pc_write_eq = (op_q == 6'h04);
        pc_write_ne = (op_q == 6'h05);
        state_d     = StFetch;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = StFetch;
      end
      StTrap: begin
        trap    = 1'b1;
        state_d = StTrap;
      end
      default: state_d = StTrap;
    endcase

    // A ready cycle or any state change leaves wait_d at zero, so entry always starts clean.
    if (in_mem_state && !mem_ready) begin
      if (wait_q == WaitLast) begin
        state_d = StTrap;
      end else begin
        wait_d = wait_q + 8'd1;
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench for multicycle_control_fsm.
// The reference model tracks each instruction as a queue of phases, built from the opcode at
// decode. Memory phases hold until mem_ready or until the wait limit.
module tb_multicycle_control_fsm;

  localparam int unsigned Limit = 15;
  localparam int unsigned NumCycles = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
  logic [1:0] pc_src, alu_src_b;
  logic [5:0] alu_op;
  logic [3:0] state_o;
  logic [21:0] dut_outs;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_WAIT_LIMIT(Limit)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_write_eq (pc_write_eq),
    .pc_write_ne (pc_write_ne),
    .pc_src      (pc_src),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .trap        (trap),
    .state_o     (state_o)
  );

  assign dut_outs = {pc_write, pc_write_eq, pc_write_ne, pc_src, iord, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, trap};

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int         ph;
  int         waits;
  logic [5:0] m_op;
  int         q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Expected output bundle for a phase, the opcode captured at decode, and the current mem_ready.
  function automatic logic [21:0] exp_outs(input int p, input logic [5:0] o, input logic rdy);
    logic pw, peq, pne, io, mr, mw, irw, rd, m2r, rw, sa, tr;
    logic [1:0] ps, sb;
    logic [5:0] ao;
    {pw, peq, pne, io, mr, mw, irw, rd, m2r, rw, sa, tr} = '0;
    ps = 2'b00;
    sb = 2'b00;
    ao = 6'h00;
    case (p)
      0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
      1:  sb = 2'b11;
      2:  begin sa = 1'b1; ao = o; end
      3:  begin sa = 1'b1; sb = 2'b10; ao = o; end
      4:  begin rw = 1'b1; rd = (o == 6'h00); end
      5:  begin sa = 1'b1; sb = 2'b10; end
      6:  begin io = 1'b1; mr = 1'b1; end
      7:  begin rw = 1'b1; m2r = 1'b1; end
      8:  begin io = 1'b1; mw = 1'b1; end
      9:  begin sa = 1'b1; ao = 6'h04; ps = 2'b01; peq = (o == 6'h04); pne = (o == 6'h05); end
      10: begin pw = 1'b1; ps = 2'b10; end
      15: tr = 1'b1;
      default: ;
    endcase
    return {pw, peq, pne, ps, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, tr};
  endfunction

  // Phases following DECODE for a given opcode.
  task automatic load_seq(input logic [5:0] o);
    q.delete();
    case (o)
      6'h00:               q = '{2, 4};
      6'h08, 6'h0d, 6'h0f: q = '{3, 4};
      6'h23:               q = '{5, 6, 7};
      6'h2b:               q = '{5, 8};
      6'h04, 6'h05:        q = '{9};
      6'h02:               q = '{10};
      default:             q = '{15};
    endcase
  endtask

  // Advance the model by one clock edge.
  task automatic model_step(input logic rst_n, input logic rdy, input logic [5:0] op_in);
    if (!rst_n) begin
      ph = 0;
      waits = 0;
      m_op = 6'h00;
      q.delete();
    end else if (ph == 15) begin
      ph = 15;
    end else if (ph == 1) begin
      m_op = op_in;
      load_seq(op_in);
      ph = q.pop_front();
      waits = 0;
    end else if ((ph == 0 || ph == 6 || ph == 8) && !rdy) begin
      waits++;
      if (waits == Limit) begin
        ph = 15;
        q.delete();
      end
    end else begin
      waits = 0;
      if (ph == 0) ph = 1;
      else if (q.size() > 0) ph = q.pop_front();
      else ph = 0;
    end
  endtask

  initial begin
    logic [5:0] legal [9];
    int  trap_cnt;
    logic stuck;
    legal = '{6'h00, 6'h08, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
    trap_cnt = 0;
    stuck = 1'b0;

    reset = 1'b0;
    mem_ready = 1'b0;
    op = 6'h00;
    zero = 1'b0;
    ph = 0;
    waits = 0;
    m_op = 6'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_state", 32'(state_o), 32'd0);
    check_eq("reset_outs", 32'(dut_outs), 32'(exp_outs(0, 6'h00, 1'b0)));

    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(negedge clk);
      trap_cnt = (ph == 15) ? trap_cnt + 1 : 0;
      reset = !(trap_cnt >= 3 || $urandom_range(63) == 0);
      if (!reset) stuck = 1'b0;
      else if (ph == 1) stuck = ($urandom_range(11) == 0);
      if (ph == 1) op = ($urandom_range(4) == 0) ? 6'($urandom) : legal[$urandom_range(8)];
      else op = 6'($urandom);
      mem_ready = stuck ? 1'b0 : ($urandom_range(3) != 0);
      zero = 1'($urandom);
      #1;
      check_eq("state", 32'(state_o), 32'(ph));
      check_eq("outputs", 32'(dut_outs), 32'(exp_outs(ph, m_op, mem_ready)));
      model_step(reset, mem_ready, op);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
